// File: rtl/fifo_arb_pkg.sv
// Shared arbitration types and the round-robin search helper used by the
// FIFO write arbiter and later read-side schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

  // First set bit of vec at or after start, wrapping modulo n (n <= RR_MAX_N).
  // Returns 0 when vec is empty; callers qualify with |vec.
  function automatic logic [31:0] rr_next(input logic [RR_MAX_N-1:0] vec,
                                          input logic [31:0]         start,
                                          input logic [31:0]         n);
    logic [31:0] idx;
    logic [31:0] cand;
    logic        hit;
    idx = 32'd0;
    hit = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      cand = (start + 32'(k)) % n;
      if ((32'(k) < n) && !hit && vec[cand[RR_IDX_W-1:0]]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first requester after i_ptr.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [RR_MAX_N-1:0] w_vec;
  logic [31:0]         w_idx_full;

  assign w_vec      = RR_MAX_N'(i_req);
  assign w_idx_full = rr_next(w_vec, 32'(i_ptr) + 32'd1, 32'(N));
  assign o_found    = |i_req;
  assign o_idx      = w_idx_full[IDX_W-1:0];

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter with burst lock in front of an async FIFO.
// Optional per-requester write counters: define FIFO_WRITE_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BITS      = 32,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned STAT_BITS = 16
) (
  input  logic                             write_clk,
  input  logic                             write_rst_n,
  input  logic [NUM_REQ-1:0]               p_req_valid,
  input  logic [NUM_REQ-1:0][BITS-1:0]     p_req_data,
  input  logic [NUM_REQ-1:0]               p_req_last,
  output logic [NUM_REQ-1:0]               p_req_ready,
  output logic                             p_fifo_write_en,
  output logic [BITS-1:0]                  p_fifo_write_data,
  input  logic                             p_fifo_write_full,
  output logic [$clog2(NUM_REQ)-1:0]       p_grant_id,
  output logic                             p_busy
`ifdef FIFO_WRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_BITS-1:0] p_stat_writes
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_nxt;
  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_owner_valid;
  logic             w_owner_last;
  logic             w_accept;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_req   (p_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_owner_valid     = p_req_valid[r_owner];
  assign w_owner_last      = p_req_last[r_owner];
  assign p_fifo_write_data = p_req_data[r_owner];
  assign p_grant_id        = r_owner;
  assign p_busy            = (r_state == ARB_LOCK);
  assign p_fifo_write_en   = w_accept;

  // Next-state, grant release and handshake decode; full stalls without releasing.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst_cnt;
    w_rr_nxt    = r_rr_ptr;
    w_accept    = 1'b0;
    p_req_ready = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_pick_idx;
          w_burst_nxt = '0;
          w_state_nxt = ARB_LOCK;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_LOCK: begin
        p_req_ready[r_owner] = !p_fifo_write_full;
        w_accept             = w_owner_valid && !p_fifo_write_full;
        if (w_accept) begin
          w_burst_nxt = r_burst_cnt + 1'b1;
          if (w_owner_last || (r_burst_cnt == BURST_LAST)) begin
            w_state_nxt = ARB_IDLE;
            w_rr_nxt    = r_owner;
          end else begin
            w_state_nxt = ARB_LOCK;
          end
        end else if (!w_owner_valid) begin
          w_state_nxt = ARB_IDLE;
          w_rr_nxt    = r_owner;
        end else begin
          w_state_nxt = ARB_LOCK;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Arbitration state registers; rr_ptr starts at the top so index 0 wins first.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_BITS-1:0] r_stat;

  // Saturating per-requester accepted-write counters.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      r_stat <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && (r_owner == IDX_W'(i)) && (r_stat[i] != {STAT_BITS{1'b1}})) begin
          r_stat[i] <= r_stat[i] + 1'b1;
        end
      end
    end
  end

  assign p_stat_writes = r_stat;
`else
  logic [STAT_BITS-1:0] w_unused_stat;
  assign w_unused_stat = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and scoreboarded checks of fifo_write_arbiter (NUM_REQ=4, BURST_MAX=4).
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int BW = 32;
  localparam int BM = 4;
  localparam int SB = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          valid;
  logic [NR-1:0][BW-1:0]  data;
  logic [NR-1:0]          last;
  logic [NR-1:0]          ready;
  logic                   we;
  logic [BW-1:0]          wdata;
  logic                   full;
  logic [1:0]             gid;
  logic                   busy;
`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [NR-1:0][SB-1:0]  stat;
`endif

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ(NR), .BITS(BW), .BURST_MAX(BM), .STAT_BITS(SB)
  ) dut (
    .write_clk         (clk),
    .write_rst_n       (rst_n),
    .p_req_valid       (valid),
    .p_req_data        (data),
    .p_req_last        (last),
    .p_req_ready       (ready),
    .p_fifo_write_en   (we),
    .p_fifo_write_data (wdata),
    .p_fifo_write_full (full),
    .p_grant_id        (gid),
    .p_busy            (busy)
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    .p_stat_writes     (stat)
`endif
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned rem[NR];
  int unsigned seq[NR];
  int unsigned exp_seq[NR];
  int unsigned sb_cnt[NR];
  logic        last_all, rnd_last, full_r, sb_on;
  logic        s_we, s_busy;
  logic [BW-1:0] s_wdata;
  logic [NR-1:0] s_ready;
  logic [1:0]  s_gid;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] word(input int i, input int unsigned s);
    logic [31:0] iv;
    logic [31:0] sv;
    iv = 32'(i);
    sv = s;
    return {iv[7:0], sv[23:0]};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      valid[i] = (rem[i] != 0);
      data[i]  = word(i, seq[i]);
      last[i]  = last_all | (rnd_last & (seq[i] % 2 == 1));
    end
    full = full_r;
  endtask

  // Sample one cycle just before the edge, account handshakes, advance and re-drive.
  task automatic tick();
    int id;
    #3;
    s_we = we; s_wdata = wdata; s_ready = ready; s_busy = busy; s_gid = gid;
    if (sb_on) begin
`ifdef FIFO_WRITE_ARB_STATS_EN
      for (int i = 0; i < NR; i++) chk("stat_count", 64'(stat[i]), 64'(sb_cnt[i]));
`endif
      chk("no_overflow", 64'(we & full), 64'd0);
      chk("we_vs_handshake", 64'(we), 64'(|(valid & ready)));
      chk("one_ready", 64'($countones(ready) <= 1), 64'd1);
      if (we) begin
        id = int'(wdata[31:24]);
        chk("id_range", 64'(id < NR), 64'd1);
        if (id < NR) begin
          chk("per_req_order", 64'(wdata), 64'(word(id, exp_seq[id])));
          exp_seq[id]++;
          sb_cnt[id]++;
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (valid[i] && ready[i]) begin
        seq[i]++;
        rem[i]--;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_seq();
    for (int i = 0; i < NR; i++) begin
      seq[i] = 0;
      exp_seq[i] = 0;
      sb_cnt[i] = 0;
    end
  endtask

  initial begin
    int ids[5];
    int sqs[5];
    int unsigned left;
    ids = '{0, 1, 2, 3, 0};
    sqs = '{0, 0, 0, 0, 1};
    sb_on = 1'b0; last_all = 1'b0; rnd_last = 1'b0; full_r = 1'b0;
    rem = '{0, 0, 0, 0};
    clear_seq();
    seq[0] = 7;
    rst_n = 1'b0;
    drive();
    #12;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gid", 64'(gid), 64'd0);
    chk("rst_data", 64'(wdata), 64'(word(0, 7)));
`ifdef FIFO_WRITE_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("rst_stat", 64'(stat[i]), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round robin, one packet word each, one bubble per grant
    clear_seq();
    last_all = 1'b1;
    rem = '{2, 1, 1, 1};
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_bubble_busy", 64'(s_busy), 64'd0);
      chk("rr_bubble_we", 64'(s_we), 64'd0);
      tick();
      chk("rr_we", 64'(s_we), 64'd1);
      chk("rr_gid", 64'(s_gid), 64'(ids[k]));
      chk("rr_data", 64'(s_wdata), 64'(word(ids[k], sqs[k])));
    end
    tick();
    chk("rr_idle", 64'(s_busy), 64'd0);

    // Quota release, then owner drop releases req2
    clear_seq();
    last_all = 1'b0;
    rem = '{0, 6, 1, 0};
    drive();
    tick();
    chk("q_arb_busy", 64'(s_busy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("q_we", 64'(s_we), 64'd1);
      chk("q_gid", 64'(s_gid), 64'd1);
      chk("q_data", 64'(s_wdata), 64'(word(1, k)));
    end
    tick();
    chk("q_release_busy", 64'(s_busy), 64'd0);
    chk("q_release_we", 64'(s_we), 64'd0);
    tick();
    chk("q_next_gid", 64'(s_gid), 64'd2);
    chk("q_next_data", 64'(s_wdata), 64'(word(2, 0)));
    chk("q_next_we", 64'(s_we), 64'd1);
    tick();
    chk("drop_busy", 64'(s_busy), 64'd1);
    chk("drop_we", 64'(s_we), 64'd0);
    tick();
    chk("drop_idle", 64'(s_busy), 64'd0);
    tick();
    chk("drop_regrant_gid", 64'(s_gid), 64'd1);
    chk("drop_regrant_data", 64'(s_wdata), 64'(word(1, 4)));
    tick();
    chk("drop_regrant_data2", 64'(s_wdata), 64'(word(1, 5)));
    tick();
    chk("drop2_we", 64'(s_we), 64'd0);
    tick();
    chk("drop2_idle", 64'(s_busy), 64'd0);

    // Full stall mid-burst after two writes
    clear_seq();
    rem = '{0, 0, 0, 8};
    drive();
    tick();
    tick();
    chk("full_w0", 64'(s_wdata), 64'(word(3, 0)));
    tick();
    chk("full_w1", 64'(s_wdata), 64'(word(3, 1)));
    full_r = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("full_we", 64'(s_we), 64'd0);
      chk("full_ready", 64'(s_ready), 64'd0);
      chk("full_busy", 64'(s_busy), 64'd1);
      chk("full_gid", 64'(s_gid), 64'd3);
      chk("full_data_hold", 64'(s_wdata), 64'(word(3, 2)));
    end
    full_r = 1'b0;
    drive();
    tick();
    chk("full_w2", 64'(s_wdata), 64'(word(3, 2)));
    chk("full_w2_we", 64'(s_we), 64'd1);
    tick();
    chk("full_w3", 64'(s_wdata), 64'(word(3, 3)));
    chk("full_w3_we", 64'(s_we), 64'd1);
    tick();
    chk("full_quota_release", 64'(s_busy), 64'd0);
    rem[3] = 0;
    drive();
    tick();
    tick();

    // Asynchronous reset in the middle of a burst
    clear_seq();
    rem = '{0, 8, 0, 0};
    drive();
    tick();
    tick();
    chk("rmid_gid", 64'(s_gid), 64'd1);
    tick();
    chk("rmid_we_before", 64'(s_we), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid_we", 64'(we), 64'd0);
    chk("rmid_ready", 64'(ready), 64'd0);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_gid_rst", 64'(gid), 64'd0);
`ifdef FIFO_WRITE_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("rmid_stat", 64'(stat[i]), 64'd0);
`endif
    clear_seq();
    last_all = 1'b1;
    rem = '{1, 0, 0, 1};
    drive();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();
    tick();
    chk("post_rst_arb", 64'(s_busy), 64'd0);
    tick();
    chk("post_rst_first_gid", 64'(s_gid), 64'd0);
    chk("post_rst_first_data", 64'(s_wdata), 64'(word(0, 0)));
    tick();
    tick();
    chk("post_rst_second_gid", 64'(s_gid), 64'd3);
    chk("post_rst_second_we", 64'(s_we), 64'd1);
    tick();

    // Random valid/full traffic against the scoreboard
    rst_n = 1'b0;
    rem = '{0, 0, 0, 0};
    clear_seq();
    last_all = 1'b0;
    rnd_last = 1'b1;
    drive();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      full_r = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < NR; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 6);
      end
      drive();
      tick();
    end
    full_r = 1'b0;
    drive();
    for (int c = 0; c < 200; c++) tick();
    left = rem[0] + rem[1] + rem[2] + rem[3];
    chk("drained", 64'(left), 64'd0);
    for (int i = 0; i < NR; i++) chk("sb_vs_producer", 64'(sb_cnt[i]), 64'(seq[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
